// File: rtl/vga_timing_gen_if.sv
// Video output bundle of vga_timing_gen.
//   master: the timing generator, which drives every signal.
//   slave : a downstream consumer such as a display PHY or a framebuffer reader.
// Signals:
//   vga_hsync, vga_vsync : sync outputs, polarity set by the generator parameters
//   vga_rgb              : pixel colour, packed {R,G,B}, CW bits per channel
//   de                   : active-video flag
//   pix_x, pix_y         : coordinates of the pixel currently on vga_rgb
//   pix_ce               : pixel-clock enable
//   line_start           : one-clk strobe on the first pixel of each line
//   frame_start          : one-clk strobe on pixel (0,0)
interface vga_timing_gen_if #(
  parameter int unsigned CW = 4
) ();
  logic            vga_hsync;
  logic            vga_vsync;
  logic [3*CW-1:0] vga_rgb;
  logic            de;
  logic [10:0]     pix_x;
  logic [10:0]     pix_y;
  logic            pix_ce;
  logic            line_start;
  logic            frame_start;

  modport master (
    output vga_hsync, vga_vsync, vga_rgb, de, pix_x, pix_y, pix_ce, line_start, frame_start
  );

  modport slave (
    input vga_hsync, vga_vsync, vga_rgb, de, pix_x, pix_y, pix_ce, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA/RGB timing and test-pattern generator.
// A prescaler divides clk into a pixel-clock enable. Horizontal and vertical counters are
// built on that enable and produce sync, data-enable, coordinates, line/frame strobes and a
// test pattern, all registered one pixel after the counter position that produces them.
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   enable    : synchronous run enable; when low, the counters and outputs clear
//   pat_mode  : 0 colour bars, 1 checkerboard, 2 grid, 3 solid colour
//   solid_rgb : colour for mode 3, packed {R,G,B}
//   vga       : output bundle (master modport)
// pat_mode and solid_rgb are sampled only at counter position (0,0), so a change takes
// effect on a frame boundary.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              pat_mode,
  input  logic [3*CW-1:0]         solid_rgb,
  vga_timing_gen_if.master        vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BW      = H_ACTIVE / 8;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PLast    = PW'(CLK_DIV - 1);
  localparam logic [10:0]   HLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0]   VLast    = 11'(V_TOTAL - 1);
  localparam logic [10:0]   HActive  = 11'(H_ACTIVE);
  localparam logic [10:0]   VActive  = 11'(V_ACTIVE);
  localparam logic [10:0]   HActLast = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   VActLast = 11'(V_ACTIVE - 1);
  localparam logic [10:0]   HSyncBeg = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VSyncBeg = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0]   BwLast   = 11'(BW - 1);

  // Counter state
  logic [PW-1:0]   presc_q, presc_d;
  logic            pix_ce_q;
  logic [10:0]     hcnt_q, hcnt_d;
  logic [10:0]     vcnt_q, vcnt_d;
  logic [10:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;

  // Pattern selection latched per frame
  logic [1:0]      mode_q, mode_eff;
  logic [3*CW-1:0] color_q, color_eff;
  logic            at_origin;

  // Next output values decoded from the current counter position
  logic            hsync_d, vsync_d, de_d, grid;
  logic [3*CW-1:0] rgb_d;

  // Registered outputs
  logic            hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [3*CW-1:0] rgb_q;
  logic [10:0]     pix_x_q, pix_y_q;

  always_comb begin
    presc_d   = (presc_q == PLast) ? '0 : presc_q + 1'b1;
    hcnt_d    = hcnt_q + 11'd1;
    vcnt_d    = vcnt_q;
    bar_cnt_d = bar_cnt_q + 11'd1;
    bar_idx_d = bar_idx_q;
    if (hcnt_q == HLast) begin
      hcnt_d    = 11'd0;
      vcnt_d    = (vcnt_q == VLast) ? 11'd0 : vcnt_q + 11'd1;
      bar_cnt_d = 11'd0;
      bar_idx_d = 3'd0;
    end else if (bar_cnt_q == BwLast) begin
      bar_cnt_d = 11'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  always_comb begin
    at_origin = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
    // Pixel (0,0) already belongs to the new frame, so it uses the freshly sampled inputs.
    mode_eff  = at_origin ? pat_mode : mode_q;
    color_eff = at_origin ? solid_rgb : color_q;

    hsync_d = ((hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd)) ? HS_POL : ~HS_POL;
    vsync_d = ((vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd)) ? VS_POL : ~VS_POL;
    de_d    = (hcnt_q < HActive) && (vcnt_q < VActive);
    grid    = (hcnt_q[4:0] == 5'd0) || (vcnt_q[4:0] == 5'd0) ||
              (hcnt_q == HActLast) || (vcnt_q == VActLast);

    case (mode_eff)
      2'd0:    rgb_d = {{CW{bar_idx_q[0]}}, {CW{bar_idx_q[1]}}, {CW{bar_idx_q[2]}}};
      2'd1:    rgb_d = {(3*CW){hcnt_q[5] ^ vcnt_q[5]}};
      2'd2:    rgb_d = {(3*CW){grid}};
      default: rgb_d = color_eff;
    endcase
    if (!de_d) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      pix_ce_q      <= 1'b0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 11'd0;
      bar_cnt_q     <= 11'd0;
      bar_idx_q     <= 3'd0;
      mode_q        <= 2'd0;
      color_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      pix_x_q       <= 11'd0;
      pix_y_q       <= 11'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (!enable) begin
      // Latched mode and colour survive a pause.
      presc_q       <= '0;
      pix_ce_q      <= 1'b0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 11'd0;
      bar_cnt_q     <= 11'd0;
      bar_idx_q     <= 3'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      pix_x_q       <= 11'd0;
      pix_y_q       <= 11'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      // Registered one clk ahead so pix_ce is high exactly while the prescaler sits at its
      // last count, and is low out of reset even when CLK_DIV is 1.
      pix_ce_q      <= (presc_d == PLast);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_ce_q) begin
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        bar_cnt_q     <= bar_cnt_d;
        bar_idx_q     <= bar_idx_d;
        mode_q        <= mode_eff;
        color_q       <= color_eff;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        de_q          <= de_d;
        rgb_q         <= rgb_d;
        pix_x_q       <= hcnt_q;
        pix_y_q       <= vcnt_q;
        line_start_q  <= (hcnt_q == 11'd0);
        frame_start_q <= at_origin;
      end
    end
  end

  assign vga.vga_hsync   = hsync_q;
  assign vga.vga_vsync   = vsync_q;
  assign vga.vga_rgb     = rgb_q;
  assign vga.de          = de_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.pix_ce      = pix_ce_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// Instance A: 64x34 active, 80x38 total, CLK_DIV=4, active-low syncs (12160 clk per frame).
// Instance B: 16x4 active, 24x7 total, CLK_DIV=1, active-high hsync (168 clk per frame).
module tb_vga_timing_gen;
  localparam int unsigned CW      = 4;
  localparam int unsigned FRAME_A = 80 * 38 * 4;

  logic          clk      = 1'b0;
  logic          reset_a  = 1'b0;
  logic          reset_b  = 1'b0;
  logic          enable_a = 1'b0;
  logic          enable_b = 1'b0;
  logic [1:0]    pat_a    = 2'd0;
  logic [1:0]    pat_b    = 2'd3;
  logic [11:0]   solid_a  = 12'h000;
  logic [11:0]   solid_b  = 12'hFFF;

  int n_assert = 0;
  int n_fail   = 0;
  int n;
  int hs_low, vs_low, de_clk, ls_cnt, fs_cnt, ce_cnt;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW)) va ();
  vga_timing_gen_if #(.CW(CW)) vb ();

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .enable    (enable_a),
    .pat_mode  (pat_a),
    .solid_rgb (solid_a),
    .vga       (va)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(CW)
  ) dut_b (
    .clk       (clk),
    .reset     (reset_b),
    .enable    (enable_b),
    .pat_mode  (pat_b),
    .solid_rgb (solid_b),
    .vga       (vb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int x, input int y, input string tag);
    int k = 0;
    while (!(va.pix_x == 11'(x) && va.pix_y == 11'(y)) && k < 20000) begin
      step();
      k++;
    end
    chk({tag, "_reach"}, 32'(k < 20000), 32'd1);
  endtask

  task automatic wait_b(input int x, input int y, input string tag);
    int k = 0;
    while (!(vb.pix_x == 11'(x) && vb.pix_y == 11'(y)) && k < 400) begin
      step();
      k++;
    end
    chk({tag, "_reach"}, 32'(k < 400), 32'd1);
  endtask

  initial begin
    #2;
    reset_a = 1'b1;
    reset_b = 1'b1;
    #1;
    chk("rst_hsync_a", 32'(va.vga_hsync), 32'd1);
    chk("rst_vsync_a", 32'(va.vga_vsync), 32'd1);
    chk("rst_de_a", 32'(va.de), 32'd0);
    chk("rst_rgb_a", 32'(va.vga_rgb), 32'h000);
    chk("rst_pix_x_a", 32'(va.pix_x), 32'd0);
    chk("rst_pix_y_a", 32'(va.pix_y), 32'd0);
    chk("rst_pix_ce_a", 32'(va.pix_ce), 32'd0);
    chk("rst_ls_a", 32'(va.line_start), 32'd0);
    chk("rst_fs_a", 32'(va.frame_start), 32'd0);
    chk("rst_hsync_b", 32'(vb.vga_hsync), 32'd0);
    chk("rst_vsync_b", 32'(vb.vga_vsync), 32'd1);
    chk("rst_pix_ce_b", 32'(vb.pix_ce), 32'd0);

    step();
    reset_a  = 1'b0;
    reset_b  = 1'b0;
    enable_a = 1'b1;
    repeat (3) step();
    chk("start_pix_ce", 32'(va.pix_ce), 32'd1);
    chk("start_fs_early", 32'(va.frame_start), 32'd0);
    step();
    chk("start_fs", 32'(va.frame_start), 32'd1);
    chk("start_x", 32'(va.pix_x), 32'd0);
    chk("start_y", 32'(va.pix_y), 32'd0);
    chk("start_de", 32'(va.de), 32'd1);
    chk("start_rgb", 32'(va.vga_rgb), 32'h000);
    step();
    chk("fs_one_clk", 32'(va.frame_start), 32'd0);
    chk("fs_hold_x", 32'(va.pix_x), 32'd0);

    // Frame 0: colour bars, 8 pixels wide
    wait_a(7, 0, "bar7");    chk("bar_x7", 32'(va.vga_rgb), 32'h000);
    wait_a(8, 0, "bar8");    chk("bar_x8", 32'(va.vga_rgb), 32'hF00);
    wait_a(16, 0, "bar16");  chk("bar_x16", 32'(va.vga_rgb), 32'h0F0);
    wait_a(24, 0, "bar24");  chk("bar_x24", 32'(va.vga_rgb), 32'hFF0);
    wait_a(32, 0, "bar32");  chk("bar_x32", 32'(va.vga_rgb), 32'h00F);
    wait_a(63, 0, "bar63");  chk("bar_x63", 32'(va.vga_rgb), 32'hFFF);
    wait_a(64, 0, "bar64");
    chk("blank_x64_rgb", 32'(va.vga_rgb), 32'h000);
    chk("blank_x64_de", 32'(va.de), 32'd0);
    wait_a(67, 0, "hs67");   chk("hsync_x67", 32'(va.vga_hsync), 32'd1);
    wait_a(68, 0, "hs68");   chk("hsync_x68", 32'(va.vga_hsync), 32'd0);
    wait_a(75, 0, "hs75");   chk("hsync_x75", 32'(va.vga_hsync), 32'd0);
    wait_a(76, 0, "hs76");   chk("hsync_x76", 32'(va.vga_hsync), 32'd1);
    pat_a = 2'd1;  // mid-frame change must wait for the next frame
    wait_a(0, 1, "ls1");
    chk("ls_line1", 32'(va.line_start), 32'd1);
    step();
    chk("ls_one_clk", 32'(va.line_start), 32'd0);
    wait_a(8, 1, "notear");  chk("no_tear_x8_y1", 32'(va.vga_rgb), 32'hF00);
    wait_a(79, 34, "vs34");  chk("vsync_y34", 32'(va.vga_vsync), 32'd1);
    wait_a(0, 35, "vs35");
    chk("vsync_y35", 32'(va.vga_vsync), 32'd0);
    chk("de_y35", 32'(va.de), 32'd0);
    wait_a(79, 36, "vs36");  chk("vsync_y36", 32'(va.vga_vsync), 32'd0);
    wait_a(0, 37, "vs37");   chk("vsync_y37", 32'(va.vga_vsync), 32'd1);

    // Frame 1: checkerboard
    wait_a(0, 0, "f1");
    chk("f1_fs", 32'(va.frame_start), 32'd1);
    chk("chk_0_0", 32'(va.vga_rgb), 32'h000);
    wait_a(32, 0, "c32_0");  chk("chk_32_0", 32'(va.vga_rgb), 32'hFFF);
    wait_a(0, 32, "c0_32");  chk("chk_0_32", 32'(va.vga_rgb), 32'hFFF);
    wait_a(32, 32, "c32_32"); chk("chk_32_32", 32'(va.vga_rgb), 32'h000);
    pat_a = 2'd2;

    // Frame 2: grid
    wait_a(0, 5, "g0_5");    chk("grid_0_5", 32'(va.vga_rgb), 32'hFFF);
    wait_a(5, 5, "g5_5");    chk("grid_5_5", 32'(va.vga_rgb), 32'h000);
    wait_a(63, 5, "g63_5");  chk("grid_63_5", 32'(va.vga_rgb), 32'hFFF);
    wait_a(5, 32, "g5_32");  chk("grid_5_32", 32'(va.vga_rgb), 32'hFFF);
    wait_a(5, 33, "g5_33");  chk("grid_5_33", 32'(va.vga_rgb), 32'hFFF);
    pat_a   = 2'd3;
    solid_a = 12'h5A3;

    // Frame 3: solid colour; switching away mid-frame must not tear
    wait_a(0, 0, "f3");      chk("solid_0_0", 32'(va.vga_rgb), 32'h5A3);
    wait_a(5, 20, "s5_20");  chk("solid_5_20", 32'(va.vga_rgb), 32'h5A3);
    pat_a   = 2'd1;
    solid_a = 12'h000;
    wait_a(32, 21, "s32_21"); chk("solid_held", 32'(va.vga_rgb), 32'h5A3);

    // Frame 4: whole-frame tallies, checkerboard spot checks
    wait_a(0, 0, "f4");
    hs_low = 0; vs_low = 0; de_clk = 0; ls_cnt = 0; fs_cnt = 0; ce_cnt = 0;
    for (int k = 0; k < int'(FRAME_A); k++) begin
      if (!va.vga_hsync) hs_low++;
      if (!va.vga_vsync) vs_low++;
      if (va.de) de_clk++;
      if (va.line_start) ls_cnt++;
      if (va.frame_start) fs_cnt++;
      if (va.pix_ce) ce_cnt++;
      if (k == 4 * 32) chk("f4_chk_32_0", 32'(va.vga_rgb), 32'hFFF);
      if (k == 4 * (32 * 80)) chk("f4_chk_0_32", 32'(va.vga_rgb), 32'hFFF);
      if (k == 4 * (32 * 80 + 32)) chk("f4_chk_32_32", 32'(va.vga_rgb), 32'h000);
      step();
    end
    chk("cnt_hsync_low", 32'(hs_low), 32'd1216);
    chk("cnt_vsync_low", 32'(vs_low), 32'd640);
    chk("cnt_de_clk", 32'(de_clk), 32'd8704);
    chk("cnt_line_start", 32'(ls_cnt), 32'd38);
    chk("cnt_frame_start", 32'(fs_cnt), 32'd1);
    chk("cnt_pix_ce", 32'(ce_cnt), 32'd3040);
    chk("f5_fs", 32'(va.frame_start), 32'd1);

    // Frame 5: pause mid-line, then resume
    wait_a(40, 3, "en40_3");
    chk("pre_pause_rgb", 32'(va.vga_rgb), 32'hFFF);
    enable_a = 1'b0;
    step();
    chk("pause_hsync", 32'(va.vga_hsync), 32'd1);
    chk("pause_vsync", 32'(va.vga_vsync), 32'd1);
    chk("pause_de", 32'(va.de), 32'd0);
    chk("pause_rgb", 32'(va.vga_rgb), 32'h000);
    chk("pause_pix_x", 32'(va.pix_x), 32'd0);
    chk("pause_pix_y", 32'(va.pix_y), 32'd0);
    chk("pause_pix_ce", 32'(va.pix_ce), 32'd0);
    step();
    enable_a = 1'b1;
    repeat (3) step();
    chk("resume_fs_early", 32'(va.frame_start), 32'd0);
    chk("resume_pix_ce", 32'(va.pix_ce), 32'd1);
    step();
    chk("resume_fs", 32'(va.frame_start), 32'd1);
    chk("resume_x", 32'(va.pix_x), 32'd0);
    chk("resume_y", 32'(va.pix_y), 32'd0);

    // Instance B: CLK_DIV=1, active-high hsync
    enable_b = 1'b1;
    n = 0;
    while (!vb.frame_start && n < 100) begin
      step();
      n++;
    end
    chk("b_first_fs", 32'(n < 100), 32'd1);
    chk("b_first_ls", 32'(vb.line_start), 32'd1);
    n = 0;
    do begin
      step();
      n++;
    end while (!vb.frame_start && n < 400);
    chk("b_frame_clk", 32'(n), 32'd168);
    chk("b_pix_ce", 32'(vb.pix_ce), 32'd1);
    wait_b(15, 0, "b15");
    chk("b_de_x15", 32'(vb.de), 32'd1);
    chk("b_rgb_x15", 32'(vb.vga_rgb), 32'hFFF);
    wait_b(16, 0, "b16");
    chk("b_de_x16", 32'(vb.de), 32'd0);
    chk("b_rgb_x16", 32'(vb.vga_rgb), 32'h000);
    wait_b(17, 0, "b17");
    chk("b_hsync_x17", 32'(vb.vga_hsync), 32'd0);
    step();
    chk("b_hs_start_x", 32'(vb.pix_x), 32'd18);
    n = 0;
    while (vb.vga_hsync && n < 50) begin
      n++;
      step();
    end
    chk("b_hsync_width", 32'(n), 32'd3);
    chk("b_hs_end_x", 32'(vb.pix_x), 32'd21);

    // Asynchronous reset between clock edges
    wait_b(19, 1, "b19_1");
    chk("b_pre_rst_hsync", 32'(vb.vga_hsync), 32'd1);
    reset_b = 1'b1;
    #1;
    chk("b_arst_hsync", 32'(vb.vga_hsync), 32'd0);
    chk("b_arst_pix_x", 32'(vb.pix_x), 32'd0);
    #1;
    reset_b = 1'b0;
    wait_b(5, 1, "b5_1");
    chk("b_pre_rst_rgb", 32'(vb.vga_rgb), 32'hFFF);
    reset_b = 1'b1;
    #1;
    chk("b_arst_rgb", 32'(vb.vga_rgb), 32'h000);
    chk("b_arst_de", 32'(vb.de), 32'd0);
    #1;
    reset_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/RGB timing and test-pattern generator for the display path.
- Divides the system clock to a pixel-clock enable and generates horizontal/vertical timing with configurable porches and sync polarity.
- Drives an RGB output of CW bits per channel from one of four selectable test patterns.
- Exports pixel coordinates, data-enable and frame/line strobes so downstream framebuffer readers can lock to it.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be a multiple of 8)
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- CLK_DIV, 4, clk cycles per pixel (≥1)
- HS_POL, 0, active level of vga_hsync
- VS_POL, 0, active level of vga_vsync
- CW, 4, bits per colour channel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  synchronous run enable
- pat_mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 grid, 3 solid
- solid_rgb  in  3*CW  colour for mode 3, packed {R,G,B}
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_rgb  out  3*CW  pixel colour, packed {R,G,B}, R in the MSBs
- de  out  1  active-video flag
- pix_x  out  11  column of the pixel currently on vga_rgb
- pix_y  out  11  row of the pixel currently on vga_rgb
- pix_ce  out  1  pixel-clock enable
- line_start  out  1  one-clk strobe: first pixel of every line
- frame_start  out  1  one-clk strobe: pixel (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be < 2048. Bar width BW = H_ACTIVE/8, computed at elaboration; no runtime divider.
- Prescaler:
  - Counts 0..CLK_DIV-1 on clk; pix_ce = 1 for the single clk where the count equals CLK_DIV-1.
  - CLK_DIV=1: pix_ce constantly 1 while enabled.
- Counters:
  - hcnt advances on pix_ce and wraps H_TOTAL-1 → 0.
  - vcnt increments on the same pix_ce where hcnt wraps, and wraps V_TOTAL-1 → 0.
  - Counters are never observed out of range.
- Output registration: all outputs register on pix_ce from (hcnt, vcnt), a latency of one pixel. vga_hsync, vga_vsync, de, vga_rgb, pix_x and pix_y are mutually aligned and hold for CLK_DIV clk cycles.
- Sync generation:
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - vsync edges coincide with hcnt=0.
- Data enable: de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE). vga_rgb is all zeros whenever de = 0.
- Strobes:
  - line_start is registered high for exactly one clk, in the same clk the outputs first show hcnt=0 (every line, blanking included).
  - frame_start is the same, but only for hcnt=0, vcnt=0.
- Patterns (full scale F = all ones):
  - Mode 0: bar index b = 0..7, tracked by a BW-pixel sub-counter reset at hcnt=0. R = F if b[0], G = F if b[1], B = F if b[2].
  - Mode 1: white if hcnt[5]^vcnt[5], else black (32×32 squares).
  - Mode 2: white if hcnt[4:0]==0, or vcnt[4:0]==0, or hcnt==H_ACTIVE-1, or vcnt==V_ACTIVE-1; else black.
  - Mode 3: latched solid_rgb.
- Input latching:
  - pat_mode and solid_rgb are latched only at the counter position hcnt=0, vcnt=0 (the pix_ce that produces frame_start).
  - A mid-frame change takes effect at the next frame; no tearing.
- Reset (asynchronous):
  - Prescaler, hcnt, vcnt = 0.
  - vga_hsync = ~HS_POL, vga_vsync = ~VS_POL.
  - de, vga_rgb, pix_x, pix_y, pix_ce, line_start, frame_start = 0.
  - Latched mode = 0, latched colour = 0.
  - Assertion mid-line forces these values immediately.
- Enable deasserted (synchronous): on the next clk, the prescaler and counters clear and all outputs take their reset values; latched mode and colour are retained.
- Enable reasserted:
  - The first pix_ce occurs CLK_DIV clk cycles later.
  - The outputs then show pixel (0,0) with frame_start.
- Simultaneous hcnt wrap and vcnt wrap: both go to 0 on the same pix_ce, and frame_start follows.

Test Plan:
- Defaults, enable=1, 2 frames → hsync low 384 clk every 3200 clk; vsync low 6400 clk every 1,680,000 clk; de high exactly 307200 pixels/frame; exactly one frame_start per frame and 525 line_start per frame.
- Mode 0, defaults → line 0 pixels 0–79 = 12'h000, 80–159 = 12'hF00, 160–239 = 12'h0F0, 560–639 = 12'hFFF; pixel 640 = 12'h000 with de=0.
- Mode 1 → (0,0)=000, (32,0)=FFF, (32,32)=000; mode 2 → (0,5)=FFF, (5,5)=000, (639,5)=FFF.
- Mode 3 with solid_rgb=12'h5A3; switch to mode 1 at line 100 → rgb stays 5A3 until the next frame_start, then the checkerboard appears.
- Deassert enable mid-line → next clk: syncs inactive, de=0, rgb=0. Reassert → frame_start after 4 clk with pix_x=pix_y=0.
- H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=1, HS_POL=1 → hsync high for 3 clk starting at pix_x=18; frame = 168 clk. Async reset asserted mid-line → hsync=0 and rgb=0 without waiting for clk.
